mem_access_stage: RTL and testbench

Fourth pipeline stage: latches the execute-stage result into an EX/MEM register and performs word loads/stores against a local data memory with a configurable wait-state count. Registers the final result into a MEM/WB register for write-back. Sits between execute and write-back. Exports EX/MEM contents for execute-stage forwarding and back-pressures execute while a memory access is in progress.

---
 rtl/mipspkg.sv | 28 ++
 rtl/data_mem.sv | 23 ++
 rtl/mem_access_stage.sv | 127 ++++++++++++
 tb/tb_mem_access_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mipspkg.sv
// Shared datapath types for the MIPS pipeline: widths, instruction/control
// records and the memory-stage FSM state.
package TYPES;

   localparam int unsigned DATA = 32;

   function automatic int unsigned addr_width(input int unsigned words);
      return $clog2(words);
   endfunction

   typedef struct packed {
      logic [5:0] opcode;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] funct;
   } Instruct;

   typedef struct packed {
      logic memread;
      logic memwrite;
      logic regwrite;
   } CTRL;

   typedef enum logic {IDLE, BUSY} mem_state_t;

endpackage

// File: rtl/data_mem.sv
// Single-port synchronous data RAM, WORDS x DATA, registered read port.
module data_mem
   import TYPES::*;
#(
   parameter int unsigned WORDS = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic            clk_i,
   input  logic            we_i,
   input  logic            re_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [DATA-1:0] wdata_i,
   output logic [DATA-1:0] rdata_o
);

   logic [DATA-1:0] mem_q [WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, wait-stated word load/store, MEM/WB register.
// Define MEM_PERF_CNT_EN to enable the aligned load/store performance counters.
module mem_access_stage
   import TYPES::*;
#(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [DATA-1:0] alu_i,
   input  logic [DATA-1:0] write_data_i,
   input  Instruct         instr_i,
   input  CTRL             cntrl_i,
   output logic [DATA-1:0] mem_data_o,
   output logic [4:0]      mem_rd_o,
   output logic            mem_regwrite_o,
   output logic            wb_valid,
   output logic [DATA-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            wb_regwrite,
   output logic            misalign_o,
   output logic [31:0]     load_cnt,
   output logic [31:0]     store_cnt
);

   localparam int unsigned AW = addr_width(MEM_WORDS);

   mem_state_t      state_q;
   logic [3:0]      cnt_q;
   logic [DATA-1:0] alu_q, wdata_q, wb_alu_q, ram_rdata;
   logic [4:0]      rd_q;
   logic            memread_q, memwrite_q, regwrite_q, mis_q, wb_load_q;
   logic            transfer, done, is_store, ram_we, ram_re, mem_op_in, aligned_in;

   assign ex_ready   = (state_q == IDLE) || (cnt_q == 4'd0);
   assign transfer   = ex_valid && ex_ready;
   assign done       = (state_q == BUSY) && (cnt_q == 4'd0);
   // memread wins when both are set, so the store half is dropped.
   assign is_store   = memwrite_q && !memread_q;
   assign ram_we     = done && is_store && !mis_q;
   assign ram_re     = done && memread_q && !mis_q;
   assign mem_op_in  = cntrl_i.memread || cntrl_i.memwrite;
   assign aligned_in = (alu_i[1:0] == 2'b00);

   assign mem_data_o     = alu_q;
   assign mem_rd_o       = rd_q;
   assign mem_regwrite_o = (state_q == BUSY) && regwrite_q && !memread_q && !memwrite_q;
   assign wb_data        = wb_load_q ? ram_rdata : wb_alu_q;

   logic unused_instr;
   assign unused_instr = ^{instr_i.opcode, instr_i.rs, instr_i.rt, instr_i.shamt, instr_i.funct};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         alu_q       <= '0;
         wdata_q     <= '0;
         rd_q        <= 5'd0;
         memread_q   <= 1'b0;
         memwrite_q  <= 1'b0;
         regwrite_q  <= 1'b0;
         mis_q       <= 1'b0;
         wb_valid    <= 1'b0;
         wb_alu_q    <= '0;
         wb_load_q   <= 1'b0;
         wb_rd       <= 5'd0;
         wb_regwrite <= 1'b0;
         misalign_o  <= 1'b0;
      end else begin
         wb_valid    <= done;
         misalign_o  <= done && mis_q;
         wb_regwrite <= done && regwrite_q && !is_store && !mis_q;
         if (done) begin
            wb_alu_q  <= alu_q;
            wb_load_q <= memread_q && !mis_q;
            wb_rd     <= rd_q;
         end
         if (transfer) begin
            state_q    <= BUSY;
            cnt_q      <= (mem_op_in && aligned_in) ? 4'(WAIT_STATES) : 4'd0;
            alu_q      <= alu_i;
            wdata_q    <= write_data_i;
            rd_q       <= instr_i.rd;
            memread_q  <= cntrl_i.memread;
            memwrite_q <= cntrl_i.memwrite;
            regwrite_q <= cntrl_i.regwrite;
            mis_q      <= mem_op_in && !aligned_in;
         end else if (done) begin
            state_q <= IDLE;
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   data_mem #(
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_data_mem (
      .clk_i   (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (alu_q[AW+1:2]),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

`ifdef MEM_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_cnt  <= 32'd0;
         store_cnt <= 32'd0;
      end else begin
         if (ram_re) load_cnt <= load_cnt + 32'd1;
         if (ram_we) store_cnt <= store_cnt + 32'd1;
      end
   end
`else
   assign load_cnt  = 32'd0;
   assign store_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table plus reset, streaming and counter sequences.
module tb_mem_access_stage;
   import TYPES::*;

   localparam int unsigned MW = 1024;
   localparam int unsigned WS = 2;

   logic        clk, rst_n, ex_valid, ex_ready;
   logic [31:0] alu_i, write_data_i, mem_data_o, wb_data, load_cnt, store_cnt;
   Instruct     instr_i;
   CTRL         cntrl_i;
   logic [4:0]  mem_rd_o, wb_rd;
   logic        mem_regwrite_o, wb_valid, wb_regwrite, misalign_o;

   int checks = 0;
   int errors = 0;

   mem_access_stage #(
      .MEM_WORDS   (MW),
      .WAIT_STATES (WS)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .alu_i          (alu_i),
      .write_data_i   (write_data_i),
      .instr_i        (instr_i),
      .cntrl_i        (cntrl_i),
      .mem_data_o     (mem_data_o),
      .mem_rd_o       (mem_rd_o),
      .mem_regwrite_o (mem_regwrite_o),
      .wb_valid       (wb_valid),
      .wb_data        (wb_data),
      .wb_rd          (wb_rd),
      .wb_regwrite    (wb_regwrite),
      .misalign_o     (misalign_o),
      .load_cnt       (load_cnt),
      .store_cnt      (store_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        mr, mw, rw;
      logic        chk_data;
      logic [31:0] exp_data;
      logic        exp_rw, exp_mis, exp_fwd;
      int          exp_lat;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, wanted 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic rw);
      alu_i            = a;
      write_data_i     = w;
      instr_i          = '0;
      instr_i.rd       = rd;
      cntrl_i.memread  = mr;
      cntrl_i.memwrite = mw;
      cntrl_i.regwrite = rw;
      ex_valid         = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int lat;
      @(negedge clk);
      drive(v.alu, v.wdata, v.rd, v.mr, v.mw, v.rw);
      chk({nm, " ex_ready idle"}, 32'(ex_ready), 32'd1);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      chk({nm, " fwd data"}, mem_data_o, v.alu);
      chk({nm, " fwd rd"}, 32'(mem_rd_o), 32'(v.rd));
      chk({nm, " fwd regwrite"}, 32'(mem_regwrite_o), 32'(v.exp_fwd));
      chk({nm, " ex_ready busy"}, 32'(ex_ready), (v.exp_lat == 1) ? 32'd1 : 32'd0);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!wb_valid && lat < 20);
      chk({nm, " latency"}, 32'(lat), 32'(v.exp_lat));
      if (v.chk_data) chk({nm, " wb_data"}, wb_data, v.exp_data);
      chk({nm, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
      chk({nm, " wb_regwrite"}, 32'(wb_regwrite), 32'(v.exp_rw));
      chk({nm, " misalign"}, 32'(misalign_o), 32'(v.exp_mis));
      @(posedge clk);
      #1;
      chk({nm, " wb_valid one cycle"}, 32'(wb_valid), 32'd0);
   endtask

   task automatic chk_zero_outputs(input string nm);
      chk({nm, " wb_valid"}, 32'(wb_valid), 32'd0);
      chk({nm, " wb_data"}, wb_data, 32'd0);
      chk({nm, " wb_rd"}, 32'(wb_rd), 32'd0);
      chk({nm, " wb_regwrite"}, 32'(wb_regwrite), 32'd0);
      chk({nm, " misalign"}, 32'(misalign_o), 32'd0);
      chk({nm, " mem_data"}, mem_data_o, 32'd0);
      chk({nm, " mem_rd"}, 32'(mem_rd_o), 32'd0);
      chk({nm, " mem_regwrite"}, 32'(mem_regwrite_o), 32'd0);
      chk({nm, " load_cnt"}, load_cnt, 32'd0);
      chk({nm, " store_cnt"}, store_cnt, 32'd0);
      chk({nm, " ex_ready"}, 32'(ex_ready), 32'd1);
   endtask

   localparam int LM = WS + 1;

   initial begin
      vec_t tmp;
      // alu, wdata, rd, mr, mw, rw, chk_data, exp_data, exp_rw, exp_mis, exp_fwd, exp_lat
      vecs[0]  = '{32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1234,
                   1'b1, 1'b0, 1'b1, 1};
      vecs[1]  = '{32'h0000_0040, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, LM};
      vecs[2]  = '{32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5,
                   1'b1, 1'b0, 1'b0, LM};
      vecs[3]  = '{32'h0000_0042, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,
                   1'b0, 1'b1, 1'b0, 1};
      vecs[4]  = '{32'h0000_0040, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5,
                   1'b1, 1'b0, 1'b0, LM};
      vecs[5]  = '{32'h0000_1000, 32'h0000_0011, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, LM};
      vecs[6]  = '{32'h0000_0000, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0011,
                   1'b1, 1'b0, 1'b0, LM};
      vecs[7]  = '{32'h0000_0044, 32'h0000_0022, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, LM};
      vecs[8]  = '{32'h0000_0044, 32'h0000_0099, 5'd11, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0022,
                   1'b1, 1'b0, 1'b0, LM};
      vecs[9]  = '{32'h0000_0044, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0022,
                   1'b1, 1'b0, 1'b0, LM};
      vecs[10] = '{32'h0000_0055, 32'h0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0055,
                   1'b0, 1'b0, 1'b0, 1};

      rst_n = 1'b0;
      ex_valid = 1'b0;
      drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      ex_valid = 1'b0;
      #1;
      chk_zero_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Known value at 0x10, then a store of 0xDEADBEEF cancelled by reset.
      tmp = '{32'h0000_0010, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b0, LM};
      run_vec(tmp, "prestore");
      @(negedge clk);
      drive(32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tmp = '{32'h0000_0010, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678,
              1'b1, 1'b0, 1'b0, LM};
      run_vec(tmp, "postreset load");

      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back ALU ops: one per cycle, each written back one edge after capture.
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k <= 3) drive(32'(k), 32'h0, 5'(k), 1'b0, 1'b0, 1'b1);
         else ex_valid = 1'b0;
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d ex_ready", k), 32'(ex_ready), 32'd1);
         if (k >= 2) begin
            chk($sformatf("stream%0d wb_valid", k), 32'(wb_valid), 32'd1);
            chk($sformatf("stream%0d wb_data", k), wb_data, 32'(k - 1));
            chk($sformatf("stream%0d wb_regwrite", k), 32'(wb_regwrite), 32'd1);
         end
      end
      @(posedge clk);
      #1;
      chk("stream idle wb_valid", 32'(wb_valid), 32'd0);

`ifdef MEM_PERF_CNT_EN
      chk("load_cnt", load_cnt, 32'd6);
      chk("store_cnt", store_cnt, 32'd3);
`else
      chk("load_cnt", load_cnt, 32'd0);
      chk("store_cnt", store_cnt, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
